// File: rtl/mmu_result_collector.sv
// Result collector below the 2-column systolic MMU: removes the one-cycle
// column skew, stores a ROWS x 2 matrix and serves registered row reads.
module mmu_result_collector #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 2,
   parameter int LAT0   = 2,
   parameter int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [DATA_W-1:0]   acc_in0,
   input  logic [DATA_W-1:0]   acc_in1,
   input  logic                rd_en,
   input  logic [RW-1:0]       rd_row,
   output logic                busy,
   output logic                done,
   output logic                rd_valid,
   output logic [2*DATA_W-1:0] rd_data
);

   localparam int LAST = LAT0 + ROWS;
   localparam int CW   = $clog2(LAST + 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] col0 [ROWS];
   logic [DATA_W-1:0] col1 [ROWS];

   logic          clear;
   logic          last;
   logic          wr0;
   logic          wr1;
   logic [RW-1:0] wr0_row;
   logic [RW-1:0] wr1_row;
   logic          rd_ok;
   logic [RW-1:0] rd_idx;

   // A start outside CAPTURE (re)launches a job; inside CAPTURE it is ignored.
   assign clear  = start && (state != CAPTURE);
   assign last   = (int'(cnt) == LAST);
   assign rd_ok  = (int'(rd_row) < ROWS);
   assign rd_idx = rd_ok ? rd_row : '0;

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      wr0     = 1'b0;
      wr1     = 1'b0;
      wr0_row = '0;
      wr1_row = '0;
      if (state == CAPTURE) begin
         if (int'(cnt) >= LAT0 && int'(cnt) < LAST) begin
            wr0     = 1'b1;
            wr0_row = RW'(int'(cnt) - LAT0);
         end
         // Column 1 trails column 0 by one cycle.
         if (int'(cnt) >= LAT0 + 1 && int'(cnt) <= LAST) begin
            wr1     = 1'b1;
            wr1_row = RW'(int'(cnt) - LAT0 - 1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = CAPTURE;
         CAPTURE: if (last)  state_nxt = DONE;
         DONE:    if (start) state_nxt = CAPTURE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CAPTURE);
      done = (state == DONE);
   end

   // NOTE: the matrix is reset because a discarded job must never leak stale results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         for (int i = 0; i < ROWS; i++) begin
            col0[i] <= '0;
            col1[i] <= '0;
         end
      end else begin
         rd_valid <= 1'b0;
         // A read in the same cycle as a restart still sees the old matrix.
         if (state == DONE && rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_ok ? {col1[rd_idx], col0[rd_idx]} : '0;
         end
         if (clear) begin
            cnt <= '0;
            for (int i = 0; i < ROWS; i++) begin
               col0[i] <= '0;
               col1[i] <= '0;
            end
         end else if (state == CAPTURE) begin
            if (wr0) col0[wr0_row] <= acc_in0;
            if (wr1) col1[wr1_row] <= acc_in1;
            if (!last) cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mmu_result_collector.sv
// Scoreboard bench for mmu_result_collector: default 2-row instance plus a
// 3-row instance whose wider row address can express an out-of-range read.
module tb_mmu_result_collector;

   logic        clk;
   logic        reset;

   logic        start;
   logic [7:0]  acc_in0;
   logic [7:0]  acc_in1;
   logic        rd_en;
   logic [0:0]  rd_row;
   logic        busy;
   logic        done;
   logic        rd_valid;
   logic [15:0] rd_data;

   logic        start3;
   logic [7:0]  acc3_0;
   logic [7:0]  acc3_1;
   logic        rd_en3;
   logic [1:0]  rd_row3;
   logic        busy3;
   logic        done3;
   logic        rd_valid3;
   logic [15:0] rd_data3;

   int checks = 0;
   int errors = 0;

   logic [15:0] q[$];
   logic [15:0] q3[$];

   mmu_result_collector #(.DATA_W(8), .ROWS(2), .LAT0(2)) dut (
      .clk(clk), .reset(reset), .start(start), .acc_in0(acc_in0), .acc_in1(acc_in1),
      .rd_en(rd_en), .rd_row(rd_row), .busy(busy), .done(done),
      .rd_valid(rd_valid), .rd_data(rd_data)
   );

   mmu_result_collector #(.DATA_W(8), .ROWS(3), .LAT0(0)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .acc_in0(acc3_0), .acc_in1(acc3_1),
      .rd_en(rd_en3), .rd_row(rd_row3), .busy(busy3), .done(done3),
      .rd_valid(rd_valid3), .rd_data(rd_data3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Read monitors: every rd_valid pops the oldest expected row.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %h with no read outstanding", rd_data);
         end else begin
            logic [15:0] exp;
            exp = q.pop_front();
            if (rd_data !== exp) begin
               errors++;
               $display("FAIL rd_data: got %h expected %h", rd_data, exp);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rd_valid3 === 1'b1) begin
         checks++;
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL rd3_unexpected: got %h with no read outstanding", rd_data3);
         end else begin
            logic [15:0] exp;
            exp = q3.pop_front();
            if (rd_data3 !== exp) begin
               errors++;
               $display("FAIL rd3_data: got %h expected %h", rd_data3, exp);
            end
         end
      end
   end

   task automatic read_row(input logic [0:0] row, input logic [15:0] exp);
      rd_en  = 1'b1;
      rd_row = row;
      q.push_back(exp);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic read_row3(input logic [1:0] row, input logic [15:0] exp);
      rd_en3  = 1'b1;
      rd_row3 = row;
      q3.push_back(exp);
      @(negedge clk);
      rd_en3 = 1'b0;
   endtask

   // Edge e is the e-th rising edge after the call; start is sampled at edge 0.
   task automatic run_job(input logic [7:0] c0r0, c0r1, c1r0, c1r1, j0, j1,
                          input bit start_mid, input bit rd_mid, input logic [15:0] hold);
      for (int e = 0; e <= 6; e++) begin
         start   = (e == 0) || (start_mid && e == 2);
         acc_in0 = (e == 3) ? c0r0 : (e == 4) ? c0r1 : j0;
         acc_in1 = (e == 4) ? c1r0 : (e == 5) ? c1r1 : (e == 6) ? (j1 ^ 8'h11) : j1;
         rd_en   = rd_mid && (e == 3);
         rd_row  = 1'b0;
         @(negedge clk);
         check($sformatf("busy_e%0d", e), busy, (e <= 4));
         check($sformatf("done_e%0d", e), done, (e >= 5));
         if (rd_mid && e == 3) begin
            check("cap_rd_valid", rd_valid, 1'b0);
            check("cap_rd_hold", rd_data, hold);
         end
      end
      start = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      acc_in0 = 8'h00;
      acc_in1 = 8'h00;
      rd_en   = 1'b0;
      rd_row  = 1'b0;
      start3  = 1'b0;
      acc3_0  = 8'h00;
      acc3_1  = 8'h00;
      rd_en3  = 1'b0;
      rd_row3 = 2'd0;

      // Asynchronous reset before any clock edge.
      #3 reset = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      rd_en = 1'b1;
      @(negedge clk);
      check("idle_rd_valid", rd_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
      rd_en = 1'b0;

      // Basic capture and back-to-back reads.
      run_job(8'h11, 8'h21, 8'h12, 8'h22, 8'hA5, 8'h5A, 1'b0, 1'b0, 16'h0000);
      read_row(1'b0, 16'h1211);
      read_row(1'b1, 16'h2221);

      // Skew isolation (0xFF at edge 3, 0xEE at edge 6) plus a read during CAPTURE.
      run_job(8'h11, 8'h21, 8'h12, 8'h22, 8'h00, 8'hFF, 1'b0, 1'b1, 16'h2221);
      read_row(1'b0, 16'h1211);
      read_row(1'b1, 16'h2221);

      // Start during CAPTURE is ignored.
      run_job(8'h11, 8'h21, 8'h12, 8'h22, 8'h5A, 8'h3C, 1'b1, 1'b0, 16'h0000);
      read_row(1'b1, 16'h2221);
      read_row(1'b0, 16'h1211);

      // Start and read together in DONE: old data returned, new job begins.
      start  = 1'b1;
      rd_en  = 1'b1;
      rd_row = 1'b0;
      q.push_back(16'h1211);
      @(negedge clk);
      start = 1'b0;
      rd_en = 1'b0;
      check("restart_busy", busy, 1'b1);
      check("restart_done", done, 1'b0);
      for (int e = 1; e <= 3; e++) begin
         acc_in0 = 8'h90 + 8'(e);
         acc_in1 = 8'hA0 + 8'(e);
         @(negedge clk);
      end

      // Reset mid-job, just before edge 4.
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_rd_valid", rd_valid, 1'b0);
      check("midrst_rd_data", rd_data, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_busy%0d", i), busy, 1'b0);
         check($sformatf("post_rst_done%0d", i), done, 1'b0);
      end

      run_job(8'h31, 8'h41, 8'h32, 8'h42, 8'h77, 8'h88, 1'b0, 1'b0, 16'h0000);
      read_row(1'b0, 16'h3231);
      read_row(1'b1, 16'h4241);

      // Three-row instance with zero latency: done after edge 4, then range checks.
      for (int e = 0; e <= 4; e++) begin
         start3 = (e == 0);
         acc3_0 = (e >= 1 && e <= 3) ? 8'(e) : 8'hC0;
         acc3_1 = (e >= 2 && e <= 4) ? (8'h80 + 8'(e - 1)) : 8'hD0;
         @(negedge clk);
         check($sformatf("busy3_e%0d", e), busy3, (e <= 3));
         check($sformatf("done3_e%0d", e), done3, (e == 4));
      end
      start3 = 1'b0;
      read_row3(2'd2, 16'h8303);
      read_row3(2'd3, 16'h0000);
      read_row3(2'd0, 16'h8101);

      @(negedge clk);
      @(negedge clk);
      check("q_drained", q.size(), 0);
      check("q3_drained", q3.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
